mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised N-channel memory request arbiter. It replaces the fixed pair of separate icache/dcache ports on the core top with one shared memory bus. Each requester channel (channel 0 = instruction fetch, channel 1 = data, extra channels for later masters) issues a valid/address/write request. The block grants one channel at a time by round-robin or fixed priority, runs a single outstanding transaction on the downstream bus, and returns a one-cycle data-valid pulse to the granted channel.

## Interface
- N_CH, 2: number of requester channels (≥2)
- ADDR_W, 64: address width
- DATA_W, 64: data width
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)
- GID_W, $clog2(N_CH): grant-id width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- ch_req_valid_i  in  N_CH  per-channel request valid
- ch_addr_i  in  N_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_wen_i  in  N_CH  per-channel write enable
- ch_wdata_i  in  N_CH*DATA_W  per-channel write data
- ch_data_valid_o  out  N_CH  one-hot response pulse
- ch_data_o  out  DATA_W  response data, broadcast to all channels
- mem_req_valid_o  out  1  downstream request valid
- mem_req_ready_i  in  1  downstream accepts request
- mem_addr_o  out  ADDR_W  latched address
- mem_wen_o  out  1  latched write enable
- mem_wdata_o  out  DATA_W  latched write data
- mem_resp_valid_i  in  1  downstream response (read data or write ack)
- mem_rdata_i  in  DATA_W  downstream read data
- busy_o  out  1  high whenever state ≠ IDLE
- grant_id_o  out  GID_W  index of the current or last granted channel

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE
  - If any ch_req_valid_i bit is set, select a winner.
  - Latch the winner's addr/wen/wdata into mem_*_o and set grant_id_o.
  - Set mem_req_valid_o=1 and go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - Hold mem_req_valid_o and payload stable until mem_req_ready_i.
  - On ready: clear mem_req_valid_o and go to WAIT.
  - If mem_resp_valid_i is high in the same cycle as ready: capture the response and go directly to RESP.
- WAIT
  - On mem_resp_valid_i: ch_data_o ← mem_rdata_i, set ch_data_valid_o[grant_id_o]=1, go to RESP.
- RESP
  - Pulse lasts exactly this one cycle. No arbitration in this state. Go to IDLE.
- Round-robin
  - Pointer last_grant; reset value N_CH-1.
  - Winner = first requesting index scanning last_grant+1 … N_CH-1, then wrapping to 0 … last_grant.
  - last_grant updates on every grant.
- Fixed priority: lowest requesting index wins. Starvation of higher indices is permitted.
- Requester contract
  - Hold req_valid and payload stable until its ch_data_valid_o pulse.
  - Deassert on the cycle after the pulse.
  - The RESP state guarantees that the request is not re-granted.
- The payload is latched at grant. Requester changes after grant do not affect the bus.
- Writes complete on mem_resp_valid_i exactly as reads do. ch_data_o takes mem_rdata_i and its value is don't-care for the requester.
- mem_resp_valid_i is ignored in IDLE and RESP, and in REQ unless mem_req_ready_i is also high.
- rst at any state
  - Next edge: IDLE, all outputs return to reset values, last_grant=N_CH-1.
  - A late response from the in-flight transaction is ignored.
- Reset values: mem_req_valid_o=0, mem_addr_o=0, mem_wen_o=0, mem_wdata_o=0, ch_data_valid_o=0, ch_data_o=0, busy_o=0, grant_id_o=0.

## Timing
- Request visible in IDLE at cycle 0 → mem_req_valid_o=1 from cycle 1.
- Ready at cycle r≥1 → WAIT from r+1.
- Response at cycle k → ch_data_valid_o high for cycle k+1 only; IDLE at k+2.
- Earliest re-issue is mem_req_valid_o at cycle k+3.
- Zero-latency path: ready and resp both at cycle 1 → data_valid at cycle 2.
- Minimum transaction is 4 cycles from request to next grant opportunity.
- ch_data_o holds its value until the next response or reset.

## Test plan
- Single read, ch0 addr 0x8000_0000
  - Stimulus: ready at cycle 1, resp at cycle 3 with rdata 0x0000_0013_0000_0093.
  - Required: mem_addr_o=0x8000_0000 at cycle 1; ch_data_valid_o=2'b01 at cycle 4 only; ch_data_o=0x0000_0013_0000_0093.
- Round-robin, N_CH=2, both channels requesting continuously from reset, memory always ready with 1-cycle response
  - Required grant order: 0, 1, 0, 1.
  - Each pulse appears only on the granted channel.
- PRIO_MODE=1, N_CH=4, channels 0 and 3 requesting continuously
  - Required: ch0 granted every transaction; ch3 is never granted; grant_id_o stays 0.
- Write from ch1: addr 0x8000_1000, wdata 0xDEAD_BEEF, wen=1
  - mem_req_ready_i held low 5 cycles.
  - Required: mem_req_valid_o and payload stable throughout the stall; mem_wen_o=1; ch_data_valid_o=2'b10 one cycle after the ack.
- Reset mid-transaction: rst asserted one cycle in WAIT, then a stale resp_valid arrives 2 cycles later
  - Required: all outputs zero after the reset edge; no ch_data_valid_o pulse; busy_o=0.
- Zero-latency: mem_req_ready_i and mem_resp_valid_i both high in the first REQ cycle
  - Required: WAIT is skipped; the pulse appears 2 cycles after the request.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N requester channels share one single-outstanding memory bus (round-robin or fixed priority).
// Latency: grant -> mem_req_valid_o next cycle; response -> one-cycle ch_data_valid_o pulse next cycle; 4-cycle minimum turnaround.
// Backpressure: mem_req_ready_i low holds mem_req_valid_o and the latched payload; requesters hold until their pulse.
// Ports: clk/rst (sync, active-high); ch_* packed per-channel requests and broadcast response; mem_* downstream bus; busy_o/grant_id_o status.
module mem_bus_arbiter #(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int PRIO_MODE = 0,
    parameter int GID_W     = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_req_valid_i,
    input  logic [N_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [N_CH-1:0]        ch_wen_i,
    input  logic [N_CH*DATA_W-1:0] ch_wdata_i,
    output logic [N_CH-1:0]        ch_data_valid_o,
    output logic [DATA_W-1:0]      ch_data_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic                   mem_wen_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic                   mem_resp_valid_i,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    output logic                   busy_o,
    output logic [GID_W-1:0]       grant_id_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [GID_W-1:0] LAST_GRANT_RST = GID_W'(N_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [GID_W-1:0]  last_grant_q, last_grant_d;
    logic [GID_W-1:0]  grant_id_q, grant_id_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [N_CH-1:0]   ch_data_valid_q, ch_data_valid_d;
    logic [DATA_W-1:0] ch_data_q, ch_data_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [GID_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic              win_wen;
    logic [DATA_W-1:0] win_wdata;

    // Winner selection. Fixed priority is round-robin with the pointer pinned at
    // the top index, so the scan always starts at channel 0. Both loops scan
    // downward so the lowest qualifying index is written last; the second loop
    // (indices past the pointer) overrides the wrapped-around first loop.
    always_comb begin
        int base;
        base      = (PRIO_MODE == 1) ? (N_CH - 1) : int'(last_grant_q);
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_req_valid_i[i] && (i <= base)) begin
                win_found = 1'b1;
                win_idx   = GID_W'(i);
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_req_valid_i[i] && (i > base)) begin
                win_found = 1'b1;
                win_idx   = GID_W'(i);
            end
        end
    end

    // Payload mux for the winning channel.
    always_comb begin
        win_addr  = '0;
        win_wen   = 1'b0;
        win_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_idx == GID_W'(i)) begin
                win_addr  = ch_addr_i[i*ADDR_W +: ADDR_W];
                win_wen   = ch_wen_i[i];
                win_wdata = ch_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_id_d      = grant_id_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        ch_data_valid_d = '0;
        ch_data_d       = ch_data_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d         = S_REQ;
                    last_grant_d    = win_idx;
                    grant_id_d      = win_idx;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = win_addr;
                    mem_wen_d       = win_wen;
                    mem_wdata_d     = win_wdata;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    // Response in the acceptance cycle skips WAIT entirely.
                    if (mem_resp_valid_i) begin
                        state_d         = S_RESP;
                        ch_data_d       = mem_rdata_i;
                        ch_data_valid_d = N_CH'(1) << grant_id_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d         = S_RESP;
                    ch_data_d       = mem_rdata_i;
                    ch_data_valid_d = N_CH'(1) << grant_id_q;
                end
            end
            // One dead cycle lets the requester drop its valid before re-arbitration.
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_grant_q    <= LAST_GRANT_RST;
            grant_id_q      <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            ch_data_valid_q <= '0;
            ch_data_q       <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_id_q      <= grant_id_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            ch_data_valid_q <= ch_data_valid_d;
            ch_data_q       <= ch_data_d;
            busy_q          <= busy_d;
        end
    end

    assign ch_data_valid_o = ch_data_valid_q;
    assign ch_data_o       = ch_data_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wen_o       = mem_wen_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign busy_o          = busy_q;
    assign grant_id_o      = grant_id_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: exercises a round-robin N_CH=2 arbiter (a_*) and a fixed-priority N_CH=4 arbiter (b_*).
// Inputs are driven and outputs sampled on the falling clock edge; "cycle n" is the period after rising edge n.
// Memory side is driven directly by the bench, including stalls and stray responses.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]   a_req, a_wen, a_dv;
    logic [127:0] a_addr, a_wdata;
    logic [63:0]  a_data, a_maddr, a_mwdata, a_rdata;
    logic         a_mvalid, a_mready, a_mwen, a_rvalid, a_busy;
    logic [0:0]   a_gid;

    logic [3:0]   b_req, b_wen, b_dv;
    logic [255:0] b_addr, b_wdata;
    logic [63:0]  b_data, b_maddr, b_mwdata, b_rdata;
    logic         b_mvalid, b_mready, b_mwen, b_rvalid, b_busy;
    logic [1:0]   b_gid;

    mem_bus_arbiter #(.N_CH(2), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .ch_req_valid_i(a_req), .ch_addr_i(a_addr), .ch_wen_i(a_wen), .ch_wdata_i(a_wdata),
        .ch_data_valid_o(a_dv), .ch_data_o(a_data),
        .mem_req_valid_o(a_mvalid), .mem_req_ready_i(a_mready), .mem_addr_o(a_maddr),
        .mem_wen_o(a_mwen), .mem_wdata_o(a_mwdata),
        .mem_resp_valid_i(a_rvalid), .mem_rdata_i(a_rdata),
        .busy_o(a_busy), .grant_id_o(a_gid)
    );

    mem_bus_arbiter #(.N_CH(4), .PRIO_MODE(1)) u_prio (
        .clk(clk), .rst(rst),
        .ch_req_valid_i(b_req), .ch_addr_i(b_addr), .ch_wen_i(b_wen), .ch_wdata_i(b_wdata),
        .ch_data_valid_o(b_dv), .ch_data_o(b_data),
        .mem_req_valid_o(b_mvalid), .mem_req_ready_i(b_mready), .mem_addr_o(b_maddr),
        .mem_wen_o(b_mwen), .mem_wdata_o(b_mwdata),
        .mem_resp_valid_i(b_rvalid), .mem_rdata_i(b_rdata),
        .busy_o(b_busy), .grant_id_o(b_gid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level expectation for the round-robin instance.
    logic [1:0]  e_dv;
    logic [63:0] e_data, e_maddr, e_mwdata;
    logic        e_mvalid, e_mwen, e_busy;
    int          e_gid, m_last;

    function automatic void model_reset();
        e_dv = '0; e_data = '0; e_maddr = '0; e_mwdata = '0;
        e_mvalid = 1'b0; e_mwen = 1'b0; e_busy = 1'b0;
        e_gid = 0; m_last = 1;
    endfunction

    // First requester strictly after 'last', wrapping around.
    function automatic int rr_pick(input logic [1:0] req, input int last);
        logic [3:0] twice;
        twice = {req, req} >> (last + 1);
        for (int p = 0; p < 2; p++) if (twice[p]) return (last + 1 + p) % 2;
        return -1;
    endfunction

    function automatic void deliver();
        e_data = a_rdata;
        e_dv   = 2'b01 << e_gid;
    endfunction

    // Advance the expectation by one cycle using the inputs currently applied.
    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
        end else if (e_dv != 2'b00) begin
            e_dv   = 2'b00;
            e_busy = 1'b0;
        end else if (!e_busy) begin
            if (a_req != 2'b00) begin
                w        = rr_pick(a_req, m_last);
                m_last   = w;
                e_gid    = w;
                e_busy   = 1'b1;
                e_mvalid = 1'b1;
                e_maddr  = a_addr[w*64 +: 64];
                e_mwen   = a_wen[w];
                e_mwdata = a_wdata[w*64 +: 64];
            end
        end else if (e_mvalid) begin
            if (a_mready) begin
                e_mvalid = 1'b0;
                if (a_rvalid) deliver();
            end
        end else if (a_rvalid) begin
            deliver();
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, ".mvalid"}, 64'(a_mvalid), 64'(e_mvalid));
        check({tag, ".maddr"},  a_maddr, e_maddr);
        check({tag, ".mwen"},   64'(a_mwen), 64'(e_mwen));
        check({tag, ".mwdata"}, a_mwdata, e_mwdata);
        check({tag, ".dv"},     64'(a_dv), 64'(e_dv));
        check({tag, ".data"},   a_data, e_data);
        check({tag, ".busy"},   64'(a_busy), 64'(e_busy));
        check({tag, ".gid"},    64'(a_gid), 64'(e_gid));
    endtask

    int   rr_exp[4] = '{0, 1, 0, 1};
    int   n_grants, n_pulses;
    logic acc_prev, mv_prev;
    logic [1:0] pend, cool;

    initial begin
        rst = 1'b1;
        a_req = '0; a_addr = '0; a_wen = '0; a_wdata = '0; a_mready = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        b_req = '0; b_addr = '0; b_wen = '0; b_wdata = '0; b_mready = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.mvalid", 64'(a_mvalid), 64'd0);
        check("rst.maddr",  a_maddr, 64'd0);
        check("rst.mwen",   64'(a_mwen), 64'd0);
        check("rst.mwdata", a_mwdata, 64'd0);
        check("rst.dv",     64'(a_dv), 64'd0);
        check("rst.data",   a_data, 64'd0);
        check("rst.busy",   64'(a_busy), 64'd0);
        check("rst.gid",    64'(a_gid), 64'd0);
        check("rst.b_mvalid", 64'(b_mvalid), 64'd0);
        check("rst.b_gid",    64'(b_gid), 64'd0);
        rst = 1'b0;

        // Single read from ch0
        @(negedge clk);                                   // cycle 0
        a_req = 2'b01; a_addr[63:0] = 64'h8000_0000; a_wen = 2'b00;
        @(negedge clk);                                   // cycle 1
        check("rd.mvalid_c1", 64'(a_mvalid), 64'd1);
        check("rd.maddr_c1",  a_maddr, 64'h8000_0000);
        check("rd.mwen",      64'(a_mwen), 64'd0);
        check("rd.gid",       64'(a_gid), 64'd0);
        check("rd.busy_c1",   64'(a_busy), 64'd1);
        a_mready = 1'b1;
        @(negedge clk);                                   // cycle 2
        check("rd.mvalid_c2", 64'(a_mvalid), 64'd0);
        a_mready = 1'b0;
        @(negedge clk);                                   // cycle 3
        check("rd.dv_c3", 64'(a_dv), 64'd0);
        a_rvalid = 1'b1; a_rdata = 64'h0000_0013_0000_0093;
        @(negedge clk);                                   // cycle 4
        check("rd.dv_c4",  64'(a_dv), 64'd1);
        check("rd.data",   a_data, 64'h0000_0013_0000_0093);
        a_rvalid = 1'b0; a_rdata = '0;
        @(negedge clk);                                   // cycle 5
        check("rd.dv_c5",   64'(a_dv), 64'd0);
        check("rd.busy_c5", 64'(a_busy), 64'd0);
        check("rd.data_hold", a_data, 64'h0000_0013_0000_0093);
        a_req = 2'b00;
        @(negedge clk);                                   // cycle 6
        check("rd.no_regrant", 64'(a_mvalid), 64'd0);

        // Write from ch1 with a 5-cycle ready stall
        a_req = 2'b10; a_addr[127:64] = 64'h8000_1000; a_wdata[127:64] = 64'hDEAD_BEEF; a_wen = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("wr.mvalid_stall", 64'(a_mvalid), 64'd1);
            check("wr.maddr_stall",  a_maddr, 64'h8000_1000);
            check("wr.mwen",         64'(a_mwen), 64'd1);
            check("wr.mwdata",       a_mwdata, 64'hDEAD_BEEF);
            check("wr.gid",          64'(a_gid), 64'd1);
            check("wr.dv_stall",     64'(a_dv), 64'd0);
            if (c == 2) a_addr[127:64] = 64'hFFFF_0000_FFFF_0000;
            a_rvalid = (c == 3);                          // response without ready is ignored
            a_mready = (c == 6);
        end
        @(negedge clk);                                   // cycle 7
        check("wr.mvalid_acc", 64'(a_mvalid), 64'd0);
        a_mready = 1'b0; a_rvalid = 1'b1; a_rdata = 64'h0000_0000_0000_1234;
        @(negedge clk);                                   // cycle 8
        check("wr.dv", 64'(a_dv), 64'd2);
        a_rvalid = 1'b0;
        @(negedge clk);                                   // cycle 9
        check("wr.dv_end", 64'(a_dv), 64'd0);
        a_req = 2'b00; a_wen = 2'b00;

        // Zero-latency: ready and response in the first REQ cycle
        @(negedge clk);                                   // cycle 0
        a_req = 2'b01; a_addr[63:0] = 64'h8000_0040;
        @(negedge clk);                                   // cycle 1
        check("zl.mvalid", 64'(a_mvalid), 64'd1);
        a_mready = 1'b1; a_rvalid = 1'b1; a_rdata = 64'hCAFE_F00D_0000_0001;
        @(negedge clk);                                   // cycle 2
        check("zl.dv",     64'(a_dv), 64'd1);
        check("zl.data",   a_data, 64'hCAFE_F00D_0000_0001);
        check("zl.mvalid_off", 64'(a_mvalid), 64'd0);
        a_mready = 1'b0; a_rvalid = 1'b0;
        @(negedge clk);                                   // cycle 3
        check("zl.dv_end", 64'(a_dv), 64'd0);
        check("zl.busy",   64'(a_busy), 64'd0);
        a_req = 2'b00;

        // Reset while waiting for the response, then a stale response
        @(negedge clk);                                   // cycle 0
        a_req = 2'b10; a_addr[127:64] = 64'h8000_2000;
        @(negedge clk);                                   // cycle 1
        check("mr.mvalid", 64'(a_mvalid), 64'd1);
        a_mready = 1'b1;
        @(negedge clk);                                   // cycle 2 (WAIT)
        check("mr.busy_wait", 64'(a_busy), 64'd1);
        a_mready = 1'b0; rst = 1'b1; a_req = 2'b00;
        @(negedge clk);                                   // cycle 3
        rst = 1'b0;
        check("mr.mvalid_z", 64'(a_mvalid), 64'd0);
        check("mr.maddr_z",  a_maddr, 64'd0);
        check("mr.mwen_z",   64'(a_mwen), 64'd0);
        check("mr.mwdata_z", a_mwdata, 64'd0);
        check("mr.dv_z",     64'(a_dv), 64'd0);
        check("mr.data_z",   a_data, 64'd0);
        check("mr.busy_z",   64'(a_busy), 64'd0);
        check("mr.gid_z",    64'(a_gid), 64'd0);
        @(negedge clk);                                   // cycle 4
        a_rvalid = 1'b1; a_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);                                   // cycle 5
        a_rvalid = 1'b0;
        check("mr.stale_dv",   64'(a_dv), 64'd0);
        check("mr.stale_busy", 64'(a_busy), 64'd0);
        @(negedge clk);                                   // cycle 6
        check("mr.stale_dv2",  64'(a_dv), 64'd0);
        check("mr.stale_data", a_data, 64'd0);

        // Round-robin from reset, both channels requesting, 1-cycle memory
        a_req = 2'b11; a_addr[63:0] = 64'h8000_0100; a_addr[127:64] = 64'h8000_0200; a_mready = 1'b1;
        n_grants = 0; n_pulses = 0; acc_prev = 1'b0; mv_prev = 1'b0;
        for (int c = 0; c < 40 && n_pulses < 4; c++) begin
            @(negedge clk);
            if (a_mvalid && !mv_prev) begin
                if (n_grants < 4) check("rr.grant", 64'(a_gid), 64'(rr_exp[n_grants]));
                n_grants++;
            end
            if (a_dv != 2'b00) begin
                check("rr.pulse", 64'(a_dv), 64'(2'b01 << rr_exp[n_pulses]));
                n_pulses++;
            end
            mv_prev  = a_mvalid;
            a_rvalid = acc_prev;
            acc_prev = a_mvalid;
        end
        check("rr.pulses", 64'(n_pulses), 64'd4);
        check("rr.grants", 64'(n_grants), 64'd4);
        a_req = 2'b00; a_rvalid = 1'b0; a_mready = 1'b0;

        // Fixed priority, channels 0 and 3 requesting continuously
        @(negedge clk);
        b_req = 4'b1001; b_addr[63:0] = 64'h8000_0300; b_addr[255:192] = 64'h8000_0400; b_mready = 1'b1;
        acc_prev = 1'b0; n_pulses = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check("pr.gid", 64'(b_gid), 64'd0);
            if (b_mvalid) check("pr.maddr", b_maddr, 64'h8000_0300);
            if (b_dv != 4'b0000) begin
                check("pr.pulse", 64'(b_dv), 64'd1);
                n_pulses++;
            end
            b_rvalid = acc_prev;
            acc_prev = b_mvalid;
        end
        check("pr.pulses", 64'(n_pulses), 64'd6);
        b_req = '0; b_rvalid = 1'b0; b_mready = 1'b0;

        // Randomized traffic against the expectation model
        rst = 1'b1; a_req = '0; a_wen = '0; a_mready = 1'b0; a_rvalid = 1'b0;
        pend = '0; cool = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 300; c++) begin
            check_a("rnd");
            for (int ch = 0; ch < 2; ch++) begin
                if (e_dv[ch]) begin
                    pend[ch] = 1'b0; cool[ch] = 1'b1; a_req[ch] = 1'b0;
                end else if (cool[ch]) begin
                    cool[ch] = 1'b0;
                end else if (!pend[ch] && $urandom_range(2) == 0) begin
                    pend[ch] = 1'b1; a_req[ch] = 1'b1;
                    a_addr[ch*64 +: 64]  = {$urandom, $urandom};
                    a_wen[ch]            = 1'($urandom_range(1));
                    a_wdata[ch*64 +: 64] = {$urandom, $urandom};
                end
            end
            a_mready = 1'($urandom_range(1));
            a_rvalid = ($urandom_range(2) == 0);
            a_rdata  = {$urandom, $urandom};
            rst      = (c == 157);
            model_step();
            @(negedge clk);
        end
        rst = 1'b0;
        check_a("rnd.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
